// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC constants and the injection arbiter state type
package noc_pkg;
  localparam int FLIT_W = 20;
  localparam int LOCAL_BUF_DEPTH = 4;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} inj_state_t;
endpackage

// File: rtl/node_inject_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot selector starting at ptr
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // scan from the farthest offset down so the nearest request at or after ptr wins
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/node_inject_arbiter.sv
// node_inject_arbiter: packet-locked round-robin injection arbiter with credit flow control; INJ_ARB_PRIO0_EN gives requester 0 priority in IDLE
module node_inject_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W = noc_pkg::FLIT_W,
  parameter int CREDITS = noc_pkg::LOCAL_BUF_DEPTH,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(CREDITS + 1)
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]         inject,
  output logic                      inject_valid,
  input  logic                      credit,
  output logic [CW-1:0]             credit_cnt,
  output logic                      err_overflow
);
  inj_state_t state;
  logic [IW-1:0] rr_ptr, owner, pick_idx, idle_idx, g;
  logic [NUM_REQ-1:0] cand, pick_gnt, idle_gnt, lock_gnt;
  logic accept, last, keep_ptr;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (.req(cand), .ptr(rr_ptr), .gnt(pick_gnt), .idx(pick_idx));

`ifdef INJ_ARB_PRIO0_EN
  assign cand = req_valid & ~NUM_REQ'(1);
  assign idle_gnt = req_valid[0] ? NUM_REQ'(1) : pick_gnt;
  assign idle_idx = req_valid[0] ? '0 : pick_idx;
  assign keep_ptr = g == '0;
`else
  assign cand = req_valid;
  assign idle_gnt = pick_gnt;
  assign idle_idx = pick_idx;
  assign keep_ptr = 1'b0;
`endif

  // grant: owner only while locked, arbitrated pick in idle, nothing without credit or in reset
  always_comb begin
    lock_gnt = NUM_REQ'(req_valid[owner]) << owner;
    req_ready = (credit_cnt != '0 && !RST) ? (state == LOCKED ? lock_gnt : idle_gnt) : '0;
    accept = |req_ready;
    g = state == LOCKED ? owner : idle_idx;
    last = req_last[g];
  end

  // packet lock FSM and round-robin pointer
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      state <= last ? IDLE : LOCKED;
      owner <= g;
      if (last && !keep_ptr) rr_ptr <= g == IW'(NUM_REQ - 1) ? '0 : g + 1'b1;
    end

  // credit counter: saturates at CREDITS and flags a surplus credit
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      credit_cnt <= CW'(CREDITS);
      err_overflow <= 1'b0;
    end else if (accept && !credit) credit_cnt <= credit_cnt - 1'b1;
    else if (credit && !accept) begin
      if (credit_cnt == CW'(CREDITS)) err_overflow <= 1'b1;
      else credit_cnt <= credit_cnt + 1'b1;
    end

  // registered injection output, one cycle after acceptance
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      inject <= '0;
      inject_valid <= 1'b0;
    end else begin
      inject_valid <= accept;
      if (accept) inject <= req_flit[g*FLIT_W +: FLIT_W];
    end
endmodule

// File: doc/node_inject_arbiter.md
# node_inject_arbiter

Shares a node's single local injection port among `NUM_REQ` on-node traffic sources. The block sits between those sources and the router's local input (port 5). It runs credit-based flow control against that input buffer using the router's `co5` credit return. It grants requesters round-robin and holds each grant for a whole multi-flit packet, so packets never interleave on the injection port.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `FLIT_W`, 20: flit width.
- `CREDITS`, 4: depth of the router's local input buffer; initial credit count.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `RST`, input, 1: asynchronous, active-high reset.
- `req_flit`, input, `NUM_REQ*FLIT_W`: flit of requester i at bits `[i*FLIT_W +: FLIT_W]`.
- `req_valid`, input, `NUM_REQ`: requester i offers a flit.
- `req_last`, input, `NUM_REQ`: the offered flit is the last flit of its packet.
- `req_ready`, output, `NUM_REQ`: one-hot; the flit of requester i is accepted this cycle.
- `inject`, output, `FLIT_W`: flit to router port 5.
- `inject_valid`, output, 1: `inject` is valid; a one-cycle pulse per flit.
- `credit`, input, 1: one-cycle pulse meaning one router buffer slot has been freed.
- `credit_cnt`, output, `$clog2(CREDITS+1)`: current credit count.
- `err_overflow`, output, 1: sticky; set when a credit arrives while `credit_cnt==CREDITS`.

## Operation
State machine has two states, IDLE and LOCKED:
- **IDLE:**
  - Candidates are requesters with `req_valid` set.
  - Pick the first candidate searching from `rr_ptr` upward, with wrap-around.
  - A pick happens only if `credit_cnt>0`.
  - On a pick g: `req_ready[g]=1` and the flit is accepted.
  - If `req_last[g]=1`: stay IDLE and set `rr_ptr <= (g+1) mod NUM_REQ`.
  - Else: go to LOCKED with `owner<=g`.
- **LOCKED:**
  - Only `owner` may be granted; all other requesters see `req_ready=0`.
  - `req_ready[owner] = req_valid[owner] && credit_cnt>0`.
  - An accepted flit with `req_last` set returns the block to IDLE and sets `rr_ptr <= (owner+1) mod NUM_REQ`.
  - Gaps in the owner's `req_valid` do not release the lock.

Credit counter:
- Next value is `credit_cnt - accept + credit`, evaluated in the same cycle.
- A credit arriving in the same cycle does NOT enable a grant when `credit_cnt==0`; there is no bypass path.
- If `credit` arrives with `credit_cnt==CREDITS` and no accept in that cycle:
  - the count saturates at `CREDITS`;
  - `err_overflow` is set and stays set until `RST`.
- The count never goes below 0, because grants require `credit_cnt>0`.

Requester handshake: a flit is transferred when `req_valid[i] && req_ready[i]`. A requester must hold its flit and `req_last` stable until accepted.

## Timing
- Reset values: IDLE, `rr_ptr=0`, `credit_cnt=CREDITS`, `inject=0`, `inject_valid=0`, `err_overflow=0`. `req_ready` is 0 during reset.
- `req_ready` is combinational from `req_valid`, state, `rr_ptr` and `credit_cnt`.
- `inject` and `inject_valid` are registered. A flit accepted in cycle N appears on `inject` with `inject_valid=1` in cycle N+1. Latency is 1 cycle.
- Throughput is 1 flit per cycle while credits remain.
- Reset mid-packet: the lock is dropped and credits return to `CREDITS`. The router must be reset by the same `RST`.

## Configuration
- `INJ_ARB_PRIO0_EN` defined: in IDLE, requester 0 wins whenever `req_valid[0]=1`. Other requesters use round-robin among themselves. Granting requester 0 does not move `rr_ptr`. LOCKED behaviour is unchanged, so requester 0 never preempts a packet in flight.
- Undefined: pure round-robin across all requesters.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_W`;
  - the default router local buffer depth (`LOCAL_BUF_DEPTH=4`);
  - a state typedef `inj_state_t` with values IDLE and LOCKED.
- One sub-module, `rr_pick`: a combinational round-robin one-hot selector taking a request vector and a start pointer, and returning a grant vector and an index.
- Credit counter, FSM and output register live in the top module.

## Test plan
1. Reset, then `req_valid=4'b0001` with a single-flit packet of `20'hABCDE` → `req_ready=4'b0001` in cycle 0; `inject=20'hABCDE` with `inject_valid=1` in cycle 1; `credit_cnt` 4→3.
2. All four requesters send continuous single-flit packets, `credit` pulsed every cycle → grant order 0,1,2,3,0,…; `credit_cnt` stays at 4 after the first grant settles.
3. Requester 2 sends a 3-flit packet while requesters 0, 1 and 3 are valid → 3 consecutive grants to 2 with no interleaving; next grant goes to 3.
4. No credits returned, requester 1 continuously valid → exactly 4 flits injected, then `req_ready=0` and `credit_cnt=0`. One `credit` pulse → one more flit, exactly 1 cycle after the credit.
5. `credit` pulsed with `credit_cnt=4` and no requests → `credit_cnt` stays 4 and `err_overflow=1` until `RST`.
6. With `INJ_ARB_PRIO0_EN` defined, requesters 0 and 3 both valid in IDLE → requester 0 granted each cycle and `rr_ptr` unchanged. Requester 3 granted once requester 0 drops valid.
